mem_arbiter: RTL and testbench

//  Shares the single unified memory block between the instruction-fetch port (F) and the

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_if.sv | 14 +
 rtl/mem_arb_pick.sv | 14 +
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, memory op codes and owner encoding for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;
  localparam logic [1:0] OP_LW = 2'd0;
  localparam logic [1:0] OP_SW = 2'd1;
  localparam logic [1:0] OP_SB = 2'd3;
  function automatic logic is_store(input logic [1:0] op);
    return op == OP_SW || op == OP_SB;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the arbiter
interface mem_arbiter_if;
  logic        f_req, f_ack, d_req, d_ack, mem_read, mem_wdata_oe;
  logic [1:0]  d_op, mem_write;
  logic [31:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  f_req, f_addr, d_req, d_op, d_addr, d_wdata, mem_rdata,
    output f_rdata, f_ack, d_rdata, d_ack, mem_addr, mem_read, mem_write, mem_wdata, mem_wdata_oe
  );
  modport master (
    output f_req, f_addr, d_req, d_op, d_addr, d_wdata, mem_rdata,
    input  f_rdata, f_ack, d_rdata, d_ack, mem_addr, mem_read, mem_write, mem_wdata, mem_wdata_oe
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-over-F priority, with F forced once it has been starved STARVE_LIMIT times
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int SW = 3
) (
  input  logic          f_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_f,
  output logic          grant_d
);
  assign grant_f = f_req && (!d_req || starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d = d_req && !grant_f;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between fetch (F) and load/store (D) ports
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES   = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(ACC_CYCLES);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]  mem_write_q, mem_write_d, sel_op;
  logic        mem_read_q, mem_read_d, oe_q, oe_d;
  logic        f_ack_q, f_ack_d, d_ack_q, d_ack_d;
  logic        grant_f, grant_d, go, done;
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_pick (
    .f_req(bus.f_req), .d_req(bus.d_req), .starve_cnt(starve_q),
    .grant_f(grant_f), .grant_d(grant_d)
  );
  assign go   = state_q == IDLE && (grant_f || grant_d);
  assign done = state_q == ACCESS && cnt_q == CW'(ACC_CYCLES - 1);
  // Fetches and the reserved op both run as a plain word load
  assign sel_op = grant_d && is_store(bus.d_op) ? bus.d_op : OP_LW;
  always_comb begin
    state_d     = go ? ACCESS : done ? RESP : state_q == RESP ? IDLE : state_q;
    owner_d     = go ? (grant_d ? OWN_D : OWN_F) : owner_q;
    cnt_d       = go ? '0 : state_q == ACCESS ? cnt_q + 1'b1 : cnt_q;
    mem_addr_d  = go ? (grant_d ? bus.d_addr : bus.f_addr) : mem_addr_q;
    mem_wdata_d = go && grant_d ? bus.d_wdata : mem_wdata_q;
    mem_read_d  = go ? !is_store(sel_op) : done ? 1'b0 : mem_read_q;
    mem_write_d = go ? sel_op : done ? 2'd0 : mem_write_q;
    oe_d        = go ? is_store(sel_op) : done ? 1'b0 : oe_q;
    f_rdata_d   = done && mem_read_q && owner_q == OWN_F ? bus.mem_rdata : f_rdata_q;
    d_rdata_d   = done && mem_read_q && owner_q == OWN_D ? bus.mem_rdata : d_rdata_q;
    f_ack_d     = done && owner_q == OWN_F;
    d_ack_d     = done && owner_q == OWN_D;
    starve_d    = !bus.f_req || (go && grant_f) ? '0 :
                  go && starve_q != SW'(STARVE_LIMIT) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 2'd0;
      oe_q        <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      oe_q        <= oe_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_wdata_oe = oe_q;
  assign bus.f_rdata      = f_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.f_ack        = f_ack_q;
  assign bus.d_ack        = d_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, fetch, load/store, priority and starvation
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.ACC_CYCLES(3), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int td, tf, nd;
    logic got;
    bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_op = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    cyc(2);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_oe", bus.mem_wdata_oe, 0);
    chk("rst_f_ack", bus.f_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_f_rdata", bus.f_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_state", dut.state_q, IDLE);
    rst = 0;
    // reset in the middle of a store
    bus.d_req = 1; bus.d_op = OP_SW; bus.d_addr = 32'h80; bus.d_wdata = 32'h12345678;
    cyc;
    chk("t1_write_on", bus.mem_write, 1);
    chk("t1_oe_on", bus.mem_wdata_oe, 1);
    rst = 1; bus.d_req = 0;
    cyc;
    chk("t1_write_off", bus.mem_write, 0);
    chk("t1_oe_off", bus.mem_wdata_oe, 0);
    chk("t1_no_ack", bus.d_ack, 0);
    cyc;
    chk("t1_state", dut.state_q, IDLE);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("t1_post_no_ack", bus.d_ack, 0);
      chk("t1_post_write", bus.mem_write, 0);
    end
    // fetch only
    bus.f_req = 1; bus.f_addr = 32'h10; bus.mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t2_read", bus.mem_read, 1);
      chk("t2_addr", bus.mem_addr, 32'h10);
      chk("t2_no_ack", bus.f_ack, 0);
      bus.f_addr = 32'h777;
    end
    cyc;
    chk("t2_ack", bus.f_ack, 1);
    chk("t2_read_off", bus.mem_read, 0);
    chk("t2_rdata", bus.f_rdata, 32'hDEADBEEF);
    chk("t2_no_d_ack", bus.d_ack, 0);
    bus.f_req = 0;
    cyc;
    chk("t2_ack_pulse", bus.f_ack, 0);
    chk("t2_idle", dut.state_q, IDLE);
    // reserved op runs as load
    bus.d_req = 1; bus.d_op = 2'd2; bus.d_addr = 32'h40; bus.mem_rdata = 32'hCAFEF00D;
    cyc;
    chk("t6_read", bus.mem_read, 1);
    chk("t6_write", bus.mem_write, 0);
    chk("t6_addr", bus.mem_addr, 32'h40);
    chk("t6_oe", bus.mem_wdata_oe, 0);
    cyc(2);
    chk("t6_write_late", bus.mem_write, 0);
    cyc;
    chk("t6_ack", bus.d_ack, 1);
    chk("t6_rdata", bus.d_rdata, 32'hCAFEF00D);
    chk("t6_f_rdata_kept", bus.f_rdata, 32'hDEADBEEF);
    chk("t6_no_f_ack", bus.f_ack, 0);
    bus.d_req = 0;
    cyc;
    chk("t6_ack_pulse", bus.d_ack, 0);
    // store byte
    bus.d_req = 1; bus.d_op = OP_SB; bus.d_addr = 32'h23; bus.d_wdata = 32'hA5;
    bus.mem_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t3_write", bus.mem_write, 3);
      chk("t3_addr", bus.mem_addr, 32'h23);
      chk("t3_oe", bus.mem_wdata_oe, 1);
      chk("t3_no_read", bus.mem_read, 0);
      chk("t3_wdata", bus.mem_wdata, 32'hA5);
      bus.d_addr = 32'h99; bus.d_wdata = 32'hFF;
    end
    cyc;
    chk("t3_ack", bus.d_ack, 1);
    chk("t3_write_off", bus.mem_write, 0);
    chk("t3_oe_off", bus.mem_wdata_oe, 0);
    chk("t3_d_rdata_kept", bus.d_rdata, 32'hCAFEF00D);
    bus.d_req = 0;
    cyc;
    // simultaneous requests
    bus.f_req = 1; bus.f_addr = 32'h200;
    bus.d_req = 1; bus.d_op = OP_LW; bus.d_addr = 32'h300; bus.mem_rdata = 32'h11112222;
    cyc;
    chk("t4_d_first", bus.mem_addr, 32'h300);
    td = -1; tf = -1;
    for (int i = 2; i <= 20 && tf < 0; i++) begin
      cyc;
      if (bus.d_ack) begin
        td = i; bus.d_req = 0; bus.mem_rdata = 32'h33334444;
      end
      if (bus.f_ack) begin
        tf = i; bus.f_req = 0;
      end
    end
    chk("t4_d_ack_time", td, 4);
    chk("t4_f_after_d", tf - td, 5);
    chk("t4_f_rdata", bus.f_rdata, 32'h33334444);
    chk("t4_d_rdata", bus.d_rdata, 32'h11112222);
    cyc;
    // starvation
    bus.d_req = 1; bus.d_op = OP_LW; bus.d_addr = 32'h500;
    bus.f_req = 1; bus.f_addr = 32'h600;
    nd = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      cyc;
      if (bus.d_ack) nd++;
      if (bus.f_ack) begin
        got = 1;
        chk("t5_starve_clr", dut.starve_q, 0);
      end
    end
    chk("t5_f_served", got, 1);
    chk("t5_d_grants", nd, 4);
    bus.f_req = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc;
      if (bus.d_ack) got = 1;
    end
    chk("t5_d_resumes", got, 1);
    bus.d_req = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
